// File: rtl/isprime.sv
// Prime-sequence generator: each rising edge of tick advances cnt_20b to the next prime,
// found by trial division with an iterative restoring remainder unit.
`timescale 1ns/1ps
module isprime #(
    parameter logic [19:0] START = 20'd2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        tick,
    output logic [19:0] cnt_20b
);
    typedef enum logic [2:0] {IDLE, NEXT, CHECK, DIV, EVAL} state_t;

    localparam logic [19:0] MAX_PRIME = 20'd1048573;

    state_t      r_state;
    logic        r_tick_s1;
    logic        r_tick_s2;
    logic        r_tick_prev;
    logic [19:0] r_cand;
    logic [10:0] r_div;
    logic [20:0] r_rem;
    logic [19:0] r_dvd;
    logic [4:0]  r_bit;
    logic [19:0] r_cnt;

    logic        w_tick_rise;
    logic [21:0] w_div_ext;
    logic [21:0] w_sq;
    logic [20:0] w_shift;
    logic [20:0] w_div_rem;
    logic        w_ge;

    assign w_tick_rise = r_tick_s2 & ~r_tick_prev;
    assign w_div_ext   = {11'd0, r_div};
    // The divisor never exceeds ~1025, so a 22-bit square cannot overflow.
    assign w_sq        = w_div_ext * w_div_ext;
    assign w_shift     = {r_rem[19:0], r_dvd[19]};
    assign w_div_rem   = {10'd0, r_div};
    assign w_ge        = (w_shift >= w_div_rem);
    assign cnt_20b     = r_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_tick_s1   <= 1'b0;
            r_tick_s2   <= 1'b0;
            r_tick_prev <= 1'b0;
            r_cand      <= 20'd0;
            r_div       <= 11'd0;
            r_rem       <= 21'd0;
            r_dvd       <= 20'd0;
            r_bit       <= 5'd0;
            r_cnt       <= START;
        end else begin
            r_tick_s1   <= tick;
            r_tick_s2   <= r_tick_s1;
            r_tick_prev <= r_tick_s2;
            case (r_state)
                IDLE: begin
                    if (w_tick_rise) begin
                        r_cand  <= r_cnt;
                        r_state <= NEXT;
                    end
                end
                NEXT: begin
                    if (r_cand == MAX_PRIME) begin
                        // Wrap-around: 2 is published directly without a search.
                        r_cand  <= 20'd2;
                        r_cnt   <= 20'd2;
                        r_state <= IDLE;
                    end else begin
                        r_cand  <= (r_cand == 20'd2) ? 20'd3 : r_cand + 20'd2;
                        r_div   <= 11'd3;
                        r_state <= CHECK;
                    end
                end
                CHECK: begin
                    if (w_sq > {2'b00, r_cand}) begin
                        r_cnt   <= r_cand;
                        r_state <= IDLE;
                    end else begin
                        r_rem   <= 21'd0;
                        r_dvd   <= r_cand;
                        r_bit   <= 5'd0;
                        r_state <= DIV;
                    end
                end
                DIV: begin
                    r_rem <= w_ge ? (w_shift - w_div_rem) : w_shift;
                    r_dvd <= {r_dvd[18:0], 1'b0};
                    r_bit <= r_bit + 5'd1;
                    if (r_bit == 5'd19) begin
                        r_state <= EVAL;
                    end
                end
                EVAL: begin
                    if (r_rem == 21'd0) begin
                        r_state <= NEXT;
                    end else begin
                        r_div   <= r_div + 11'd2;
                        r_state <= CHECK;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_isprime.sv
// Self-checking bench for isprime: table-driven tick sequences on three preloaded
// instances plus fast-tick, async-reset and held-tick corner cases.
`timescale 1ns/1ps
module tb_isprime;
    logic        clk;
    logic        rstn_a, rstn_b, rstn_c;
    logic        tick_a, tick_b, tick_c;
    logic [19:0] cnt_a, cnt_b, cnt_c;

    int checks = 0;
    int errors = 0;
    logic bad_seen = 1'b0;

    isprime #(.START(20'd2))       u_a (.clk(clk), .rstn(rstn_a), .tick(tick_a), .cnt_20b(cnt_a));
    isprime #(.START(20'd1009))    u_b (.clk(clk), .rstn(rstn_b), .tick(tick_b), .cnt_20b(cnt_b));
    isprime #(.START(20'd1048573)) u_c (.clk(clk), .rstn(rstn_c), .tick(tick_c), .cnt_20b(cnt_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cnt_a == 20'd9 || cnt_a == 20'd15) bad_seen = 1'b1;
    end

    typedef struct {
        int          sel;
        logic [19:0] exp;
    } vec_t;

    vec_t vecs[14];

    function automatic logic [19:0] cnt_of(input int sel);
        case (sel)
            0:       return cnt_a;
            1:       return cnt_b;
            default: return cnt_c;
        endcase
    endfunction

    function automatic bit is_prime(input int unsigned n);
        if (n < 2) return 1'b0;
        for (int unsigned d = 2; d * d <= n; d++) begin
            if (n % d == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [19:0] next_prime(input logic [19:0] p);
        int unsigned n;
        if (p == 20'd1048573) return 20'd2;
        n = p + 1;
        while (!is_prime(n)) n++;
        return n[19:0];
    endfunction

    task automatic check(input string name, input logic [19:0] got, input logic [19:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic set_tick(input int sel, input logic v);
        case (sel)
            0:       tick_a = v;
            1:       tick_b = v;
            default: tick_c = v;
        endcase
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Raise tick, wait (bounded) for the output to move, check it, confirm a held tick
    // gives no second advance, then drop tick for the rest of a slow period.
    task automatic do_tick(input int sel, input logic [19:0] exp, input string name);
        logic [19:0] prev;
        bit          changed;
        prev    = cnt_of(sel);
        changed = 1'b0;
        set_tick(sel, 1'b1);
        for (int i = 0; i < 20000 && !changed; i++) begin
            @(negedge clk);
            if (cnt_of(sel) != prev) changed = 1'b1;
        end
        check(name, cnt_of(sel), exp);
        wait_cycles(200);
        check({name, "_held"}, cnt_of(sel), exp);
        set_tick(sel, 1'b0);
        wait_cycles(800);
    endtask

    initial begin
        logic [19:0] prev;
        logic [19:0] cur;
        int          changes;
        bit          held_ok;

        vecs[0]  = '{0, 20'd3};
        vecs[1]  = '{0, 20'd5};
        vecs[2]  = '{0, 20'd7};
        vecs[3]  = '{0, 20'd11};
        vecs[4]  = '{0, 20'd13};
        vecs[5]  = '{0, 20'd17};
        vecs[6]  = '{0, 20'd19};
        vecs[7]  = '{0, 20'd23};
        vecs[8]  = '{0, 20'd29};
        vecs[9]  = '{0, 20'd31};
        vecs[10] = '{1, 20'd1013};
        vecs[11] = '{1, 20'd1019};
        vecs[12] = '{2, 20'd2};
        vecs[13] = '{2, 20'd3};

        rstn_a = 1'b0; rstn_b = 1'b0; rstn_c = 1'b0;
        tick_a = 1'b0; tick_b = 1'b0; tick_c = 1'b0;
        wait_cycles(4);
        rstn_a = 1'b1; rstn_b = 1'b1; rstn_c = 1'b1;
        @(negedge clk);
        check("reset_a", cnt_a, 20'd2);
        check("reset_b", cnt_b, 20'd1009);
        check("reset_c", cnt_c, 20'd1048573);

        held_ok = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (cnt_a != 20'd2) held_ok = 1'b0;
        end
        check("idle_hold_1000", {19'd0, held_ok}, 20'd1);

        for (int i = 0; i < 14; i++) begin
            do_tick(vecs[i].sel, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Reset mid-search on the 1009 instance (now at 1019, searching toward 1021).
        tick_b = 1'b1;
        wait_cycles(40);
        check("hold_during_search", cnt_b, 20'd1019);
        #2 rstn_b = 1'b0;
        #1 check("async_reset", cnt_b, 20'd1009);
        tick_b = 1'b0;
        wait_cycles(5);
        check("reset_held", cnt_b, 20'd1009);
        rstn_b = 1'b1;
        wait_cycles(10);
        check("no_partial_update", cnt_b, 20'd1009);
        do_tick(1, 20'd1013, "restart");

        // Fast tick: every observed update must be the next prime after the previous one.
        rstn_a = 1'b0;
        tick_a = 1'b0;
        wait_cycles(3);
        rstn_a = 1'b1;
        prev    = cnt_a;
        changes = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 5 == 0) tick_a = ~tick_a;
            @(negedge clk);
            cur = cnt_a;
            if (cur != prev) begin
                check("fast_step", cur, next_prime(prev));
                prev = cur;
                changes++;
            end
        end
        check("fast_progress", {19'd0, changes >= 10}, 20'd1);
        tick_a = 1'b0;

        check("no_composite", {19'd0, bad_seen}, 20'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
